alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FIRST_PRIO, default 0: the requester (0 or 1) that holds priority after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0, req1  input  1 each  request from requester 0 and requester 1.
REQ-005 Ain0, Bin0, Ain1, Bin1  input  4 each  operands of requester 0 and requester 1.
REQ-006 ALUop0, ALUop1  input  3 each  operation code of requester 0 and requester 1.
REQ-007 Ain, Bin  output  4 each  registered operands driven to the shared ALU.
REQ-008 ALUop  output  3  registered op code driven to the shared ALU.
REQ-009 ALUout  input  4  combinational result returned by the shared ALU.
REQ-010 gnt0, gnt1  output  1 each  one-cycle grant pulse to the selected requester.
REQ-011 done0, done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-012 Result  output  4  last captured ALU result; holds until the next completion.
REQ-013 busy  output  1  high while the FSM is in EXEC.
REQ-014 opCount  output  8  number of completed operations; wraps modulo 256.

Function
REQ-015 The FSM SHALL have two states: IDLE and EXEC.
REQ-016 In IDLE with no request active, the FSM SHALL stay in IDLE, and Ain, Bin and ALUop SHALL hold their values.
REQ-017 In IDLE with exactly one request active, at the clock edge the block SHALL grant that requester, latch its Ain/Bin/ALUop onto the ALU ports, pulse its gnt for one cycle, and enter EXEC.
REQ-018 In IDLE with both requests active, the block SHALL grant the requester named by the priority pointer.
REQ-019 The priority pointer SHALL move to the other requester after each completed operation (round-robin), so neither requester waits more than one operation.
REQ-020 In EXEC, at the next clock edge the block SHALL:
- capture ALUout into Result;
- pulse the granted requester's done for one cycle;
- increment opCount;
- return to IDLE.
REQ-021 Timing SHALL be as follows:
- a request sampled at edge N produces gnt high in cycle N..N+1;
- done and the new Result appear after edge N+1;
- maximum throughput is one operation every 2 cycles.
REQ-022 In the cycle where done is high, the FSM SHALL already be in IDLE and SHALL be able to accept a new request at the next edge.
REQ-023 Requests SHALL be sampled only in IDLE; a req held high through EXEC SHALL be treated as a new request once the FSM returns to IDLE.
REQ-024 A requester SHALL deassert req in the cycle gnt is seen, unless it wants another operation.
REQ-025 Operand and op inputs SHALL be sampled only at the grant edge; changes during EXEC SHALL have no effect.
REQ-026 gnt0 and gnt1 SHALL never be high together, and done0 and done1 SHALL never be high together.
REQ-027 opCount SHALL wrap from 255 to 0 with no other side effect.

Reset
REQ-028 While reset is high, and immediately on its assertion, the block SHALL set:
- state to IDLE;
- Ain, Bin, Result and opCount to 0;
- ALUop to 3'b000;
- gnt0, gnt1, done0, done1 and busy to 0;
- the priority pointer to FIRST_PRIO.
REQ-029 Reset asserted during EXEC SHALL abort the operation: no done pulse, and Result and opCount are not updated.
REQ-030 After reset releases, the first edge with a request present SHALL grant per REQ-017 and REQ-018.

Verification
REQ-031 Single request: req0=1, Ain0=4'h6, Bin0=4'h3, ALUop0=3'b101 → gnt0 pulses one cycle, then done0 pulses with Result=4'h9 and opCount=1.
REQ-032 Contention with FIRST_PRIO=0: req0 and req1 held high for 4 operations → grants in the order 0,1,0,1, each done matching its gnt, opCount=4.
REQ-033 Wrap-around: requester 1 with Ain1=4'h2, Bin1=4'h5, ALUop1=3'b100 → Result=4'hD; 256 operations → opCount returns to 0.
REQ-034 Operand change during EXEC: change Ain0 from 4'h1 to 4'hF after gnt0, with ALUop0=3'b000 → Result=4'h1.
REQ-035 Reset mid-op: assert reset in EXEC → no done pulse, all outputs 0, opCount=0; after release, a fresh req1 is granted first when FIRST_PRIO=1.
REQ-036 Idle hold: no requests for 10 cycles → busy=0, ALU ports stable, no gnt or done pulses.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// A grant latches the winner's operands onto the ALU ports. The result is
// captured one cycle later. When both requesters ask at once, a round-robin
// pointer decides the winner.
module alu_arbiter #(
  parameter int FIRST_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] Ain0,
  input  logic [3:0] Bin0,
  input  logic [3:0] Ain1,
  input  logic [3:0] Bin1,
  input  logic [2:0] ALUop0,
  input  logic [2:0] ALUop1,
  output logic [3:0] Ain,
  output logic [3:0] Bin,
  output logic [2:0] ALUop,
  input  logic [3:0] ALUout,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] Result,
  output logic       busy,
  output logic [7:0] opCount
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t state;
  logic   prio;
  logic   owner;
  logic   pick;

  // Winner selection: a lone requester wins outright; on a tie the pointer decides
  always_comb begin
    pick = 1'b0;
    if (req1 && (!req0 || prio)) pick = 1'b1;
  end

  // Arbitration FSM with registered ALU ports, pulses, result and counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      prio    <= (FIRST_PRIO != 0);
      owner   <= 1'b0;
      Ain     <= 4'h0;
      Bin     <= 4'h0;
      ALUop   <= 3'b000;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      Result  <= 4'h0;
      busy    <= 1'b0;
      opCount <= 8'h00;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= pick;
            busy  <= 1'b1;
            state <= EXEC;
            if (pick) begin
              Ain   <= Ain1;
              Bin   <= Bin1;
              ALUop <= ALUop1;
              gnt1  <= 1'b1;
            end else begin
              Ain   <= Ain0;
              Bin   <= Bin0;
              ALUop <= ALUop0;
              gnt0  <= 1'b1;
            end
          end
        end
        EXEC: begin
          Result  <= ALUout;
          opCount <= opCount + 8'd1;
          prio    <= ~owner;
          busy    <= 1'b0;
          state   <= IDLE;
          if (owner) done1 <= 1'b1;
          else       done0 <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
